// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: eight-digit multiplexed 7-segment display controller.
// Two 4-digit banks are scanned in parallel. Data writes are staged in a
// pending register and only reach the display at a frame boundary, so a
// frame never mixes old and new digits. A control register adds
// leading-zero blanking, a blink gate on the digit enables, and a
// per-digit decimal point mask.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        seg_write,
   input  logic        seg_addr,
   input  logic [31:0] seg_wdata,
   output logic [3:0]  ena_r,
   output logic [3:0]  ena_l,
   output logic [7:0]  led_r,
   output logic [7:0]  led_l
);

   localparam int              PW         = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
   localparam logic [7:0]      FRAME_LAST = 8'(BLINK_DIV - 1);

   // Hex nibble to active-high segments a..g (bit0 = a).
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Bit k set when digit k and every digit above it are zero; digit 0 is
   // never marked so a zero value still shows a single "0".
   function automatic logic [7:0] lead_zero_mask(input logic [31:0] value);
      logic [7:0] mask;
      mask = 8'h00;
      for (int k = 1; k < 8; k++) begin
         mask[k] = ((value >> (4 * k)) == 32'd0);
      end
      return mask;
   endfunction

   logic [PW-1:0] presc_r;
   logic [1:0]    idx_r;
   logic [7:0]    frame_cnt_r;
   logic          blink_phase_r;
   logic [31:0]   pending_r;
   logic [31:0]   display_r;
   logic          blank_en_r;
   logic          blink_en_r;
   logic [7:0]    dp_mask_r;

   logic          tc_s;
   logic          frame_s;
   logic          data_wr_s;
   logic          ctrl_wr_s;
   logic          blink_chg_s;
   logic [3:0]    dig_r_s;
   logic [3:0]    dig_l_s;
   logic [7:0]    zmask_s;
   logic          blank_r_s;
   logic          blank_l_s;
   logic [3:0]    ena_s;
   logic [7:0]    led_r_s;
   logic [7:0]    led_l_s;

   // Decode of scan events and write strobes.
   always_comb begin
      tc_s        = (presc_r == PRESC_LAST);
      frame_s     = tc_s && (idx_r == 2'd3);
      data_wr_s   = seg_write && !seg_addr;
      ctrl_wr_s   = seg_write && seg_addr;
      blink_chg_s = ctrl_wr_s && (seg_wdata[1] != blink_en_r);
   end

   // Prescaler and digit position; writes never stall the scan.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_r <= '0;
         idx_r   <= 2'd0;
      end else if (tc_s) begin
         presc_r <= '0;
         idx_r   <= idx_r + 2'd1;
      end else begin
         presc_r <= presc_r + PRESC_ONE;
      end
   end

   // Pending/display staging; a write on the boundary cycle goes straight through.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_r <= 32'd0;
         display_r <= 32'd0;
      end else begin
         if (data_wr_s) begin
            pending_r <= seg_wdata;
         end
         if (frame_s) begin
            display_r <= data_wr_s ? seg_wdata : pending_r;
         end
      end
   end

   // Control register: blanking, blink enable, decimal point mask.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blank_en_r <= 1'b0;
         blink_en_r <= 1'b0;
         dp_mask_r  <= 8'h00;
      end else if (ctrl_wr_s) begin
         blank_en_r <= seg_wdata[0];
         blink_en_r <= seg_wdata[1];
         dp_mask_r  <= seg_wdata[15:8];
      end
   end

   // Blink timebase in frames; restarted whenever the blink enable changes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         frame_cnt_r   <= 8'd0;
         blink_phase_r <= 1'b0;
      end else if (blink_chg_s) begin
         frame_cnt_r   <= 8'd0;
         blink_phase_r <= 1'b0;
      end else if (frame_s) begin
         if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_r   <= 8'd0;
            blink_phase_r <= !blink_phase_r;
         end else begin
            frame_cnt_r   <= frame_cnt_r + 8'd1;
         end
      end
   end

   // Next output values from current position, display and control state.
   always_comb begin
      dig_r_s   = display_r[{idx_r, 2'b00} +: 4];
      dig_l_s   = display_r[{1'b1, idx_r, 2'b00} +: 4];
      zmask_s   = lead_zero_mask(display_r);
      blank_r_s = blank_en_r && zmask_s[{1'b0, idx_r}];
      blank_l_s = blank_en_r && zmask_s[{1'b1, idx_r}];
      if (blink_en_r && blink_phase_r) begin
         ena_s = 4'b0000;
      end else begin
         ena_s = 4'b0001 << idx_r;
      end
      led_r_s = {dp_mask_r[{1'b0, idx_r}], blank_r_s ? 7'h00 : hex_to_seg(dig_r_s)};
      led_l_s = {dp_mask_r[{1'b1, idx_r}], blank_l_s ? 7'h00 : hex_to_seg(dig_l_s)};
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ena_r <= 4'b0000;
         ena_l <= 4'b0000;
         led_r <= 8'h00;
         led_l <= 8'h00;
      end else begin
         ena_r <= ena_s;
         ena_l <= ena_s;
         led_r <= led_r_s;
         led_l <= led_l_s;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-count based reference model
// pushes the expected outputs each clock; a monitor pops and compares.
module tb_seg7_scan_ctrl;

   localparam int SD = 4;
   localparam int BD = 2;
   localparam int FRAME = 4 * SD;
   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      logic [3:0] er;
      logic [3:0] el;
      logic [7:0] lr;
      logic [7:0] ll;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        seg_write = 1'b0;
   logic        seg_addr = 1'b0;
   logic [31:0] seg_wdata = 32'd0;
   logic [3:0]  ena_r, ena_l;
   logic [7:0]  led_r, led_l;

   int total = 0;
   int bad = 0;

   exp_t q[$];

   // reference model state
   int          m_cyc = 0;
   int          m_fsc = 0;
   logic [31:0] m_pend = 32'd0;
   logic [31:0] m_disp = 32'd0;
   logic        m_blank = 1'b0;
   logic        m_blink = 1'b0;
   logic [7:0]  m_dp = 8'h00;

   seg7_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clock(clock), .reset(reset), .seg_write(seg_write), .seg_addr(seg_addr),
      .seg_wdata(seg_wdata), .ena_r(ena_r), .ena_l(ena_l), .led_r(led_r), .led_l(led_l));

   always #5 clock = ~clock;

   function automatic logic [7:0] model_led(input int k);
      logic [3:0] nib;
      logic [6:0] seg;
      nib = 4'((m_disp >> (4 * k)) & 32'hF);
      if (m_blank && k != 0 && (m_disp >> (4 * k)) == 32'd0) seg = 7'h00;
      else seg = SEG_TAB[nib];
      return {m_dp[k], seg};
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int pos;
      pos = (m_cyc / SD) % 4;
      if (m_blink && ((m_fsc / BD) % 2 == 1)) e.er = 4'b0000;
      else e.er = 4'(1 << pos);
      e.el = e.er;
      e.lr = model_led(pos);
      e.ll = model_led(pos + 4);
      return e;
   endfunction

   task automatic model_clear();
      m_cyc = 0; m_fsc = 0; m_pend = 32'd0; m_disp = 32'd0;
      m_blank = 1'b0; m_blink = 1'b0; m_dp = 8'h00;
   endtask

   // model: expected output for this edge, then apply the inputs seen at it
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            bit boundary;
            q.push_back(model_out());
            boundary = (m_cyc % FRAME) == FRAME - 1;
            if (seg_write && !seg_addr) begin
               m_pend = seg_wdata;
               if (boundary) m_disp = seg_wdata;
            end else if (boundary) begin
               m_disp = m_pend;
            end
            if (boundary) m_fsc++;
            if (seg_write && seg_addr) begin
               if (seg_wdata[1] != m_blink) m_fsc = 0;
               m_blank = seg_wdata[0];
               m_blink = seg_wdata[1];
               m_dp    = seg_wdata[15:8];
            end
            m_cyc++;
         end
      end
   end

   // monitor: compare on the falling edge, away from the active edge
   initial begin
      forever begin
         @(negedge clock);
         if (!reset || q.size() == 0) begin
            total++;
            if ({ena_r, ena_l, led_r, led_l} != 24'd0) begin
               bad++;
               $display("FAIL idle_zero t=%0t: got ena_r=%b ena_l=%b led_r=%h led_l=%h, want all zero",
                        $time, ena_r, ena_l, led_r, led_l);
            end
         end else begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (ena_r !== e.er || ena_l !== e.el || led_r !== e.lr || led_l !== e.ll) begin
               bad++;
               $display("FAIL scan_out t=%0t: got ena_r=%b ena_l=%b led_r=%h led_l=%h, want ena_r=%b ena_l=%b led_r=%h led_l=%h",
                        $time, ena_r, ena_l, led_r, led_l, e.er, e.el, e.lr, e.ll);
            end
         end
      end
   end

   task automatic cyc(input logic w, input logic a, input logic [31:0] d);
      seg_write = w; seg_addr = a; seg_wdata = d;
      @(posedge clock); #2;
      seg_write = 1'b0; seg_addr = 1'b0; seg_wdata = 32'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0);
   endtask

   task automatic wait_phase(input int ph);
      int guard = 0;
      while ((m_cyc % FRAME) != ph && guard < 2 * FRAME) begin
         idle(1);
         guard++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      total++;
      if ({ena_r, ena_l, led_r, led_l} != 24'd0) begin
         bad++;
         $display("FAIL reset_async: got ena_r=%b ena_l=%b led_r=%h led_l=%h, want all zero",
                  ena_r, ena_l, led_r, led_l);
      end
      q.delete();
      model_clear();
      @(posedge clock); @(posedge clock); #2;
      reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();
      // frame 0 data write
      cyc(1'b1, 1'b0, 32'h12345678);
      idle(40);
      // mid-frame write superseded by a write on the boundary cycle
      wait_phase(5);
      cyc(1'b1, 1'b0, 32'hAAAAAAAA);
      wait_phase(FRAME - 1);
      cyc(1'b1, 1'b0, 32'h0000000F);
      idle(36);
      // leading-zero blanking
      cyc(1'b1, 1'b1, 32'h00000001);
      cyc(1'b1, 1'b0, 32'h00000300);
      idle(40);
      cyc(1'b1, 1'b0, 32'h00000000);
      idle(40);
      // blink with decimal points on digits 0 and 1
      cyc(1'b1, 1'b1, 32'h00000302);
      idle(8 * FRAME);
      // reset during the blink-off phase with a pending write
      begin
         int guard = 0;
         while (!(m_blink && ((m_fsc / BD) % 2 == 1)) && guard < 8 * FRAME) begin
            idle(1);
            guard++;
         end
         total++;
         if (guard >= 8 * FRAME) begin
            bad++;
            $display("FAIL blink_off_wait: got no blink-off phase within %0d cycles, want one", guard);
         end
      end
      wait_phase(3);
      cyc(1'b1, 1'b0, 32'hDEADBEEF);
      idle(3);
      do_reset();
      idle(40);
      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         int r;
         r = int'($urandom_range(0, 15));
         if (i == 350) do_reset();
         if (r < 3) cyc(1'b1, 1'b0, $urandom >> $urandom_range(0, 31));
         else if (r == 3) cyc(1'b1, 1'b1, $urandom);
         else idle(1);
      end
      idle(4);
      @(negedge clock); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
